// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point FFT result streamer.
// Build option: FFT_STREAM_BITREV_EN selects bit-reversed buffer readout.
package fft_pkg;

  localparam int FFT_N  = 8;
  localparam int FFT_W  = 16;
  localparam int FFT_IW = 3;

  typedef struct packed {
    logic [FFT_W-1:0] re;
    logic [FFT_W-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Reverses the low iw bits of idx; bits above iw come back as zero.
  function automatic logic [FFT_IW-1:0] bitrev(input logic [FFT_IW-1:0] idx, input int iw);
    logic [FFT_IW-1:0] r;
    r = {<<{idx}};
    return r >> (FFT_IW - iw);
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// N-entry complex register file: whole-frame capture write, one indexed read.
module fft_frame_buf
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [FFT_N*FFT_W-1:0]  wr_real,
  input  logic [FFT_N*FFT_W-1:0]  wr_imag,
  input  logic [FFT_IW-1:0]       rd_idx,
  output cplx_t                   rd_data
);

  cplx_t mem [FFT_N];

  // NOTE: no reset on the storage -- every entry is rewritten by a capture
  // before the streamer can read it, so plain enable flops are enough.
  // NOTE: sequential state uses non-blocking assignments so all entries
  // update together at the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < FFT_N; k++) begin
        mem[k].re <= wr_real[k*FFT_W +: FFT_W];
        mem[k].im <= wr_imag[k*FFT_W +: FFT_W];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fft_8_result_streamer.sv
// Captures an FFT result frame on fft_done and replays it on a valid/ready stream.
// Build option: FFT_STREAM_BITREV_EN streams a bit-reversed core output in natural order.
module fft_8_result_streamer
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fft_done,
  input  logic [FFT_N*FFT_W-1:0]  fft_real,
  input  logic [FFT_N*FFT_W-1:0]  fft_imag,
  output logic                    cap_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FFT_W-1:0]        out_real,
  output logic [FFT_W-1:0]        out_imag,
  output logic [FFT_IW-1:0]       out_idx,
  output logic                    out_last,
  output logic                    overrun,
  input  logic                    clr_overrun
);

  localparam logic [FFT_IW-1:0] LAST_IDX = FFT_IW'(FFT_N - 1);

  state_t             state_q, state_d;
  logic [FFT_IW-1:0]  cnt_q, cnt_d, nxt_cnt, rd_idx;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               ovr_q, ovr_d;
  logic [FFT_W-1:0]   re_q, re_d, im_q, im_d;
  cplx_t              rd_data;
  logic               hs, last_hs, capture, drop;

  assign hs        = valid_q & out_ready;
  assign last_hs   = hs & last_q;
  assign cap_ready = (state_q == IDLE) | last_hs;
  assign capture   = fft_done & cap_ready;
  assign drop      = fft_done & ~cap_ready;
  assign nxt_cnt   = cnt_q + 1'b1;

`ifdef FFT_STREAM_BITREV_EN
  assign rd_idx = bitrev(nxt_cnt, FFT_IW);
`else
  assign rd_idx = nxt_cnt;
`endif

  fft_frame_buf u_buf (
    .clk     (clk),
    .wr_en   (capture),
    .wr_real (fft_real),
    .wr_imag (fft_imag),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // NOTE: every variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    re_d    = re_q;
    im_d    = im_q;

    case (state_q)
      IDLE: ;
      STREAM: begin
        if (last_hs) begin
          state_d = IDLE;
          cnt_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (hs) begin
          cnt_d  = nxt_cnt;
          last_d = (nxt_cnt == LAST_IDX);
          re_d   = rd_data.re;
          im_d   = rd_data.im;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bin 0 lives at buffer position 0 in either order, so the first beat
    // is taken straight from the core while the buffer is being written.
    if (capture) begin
      state_d = STREAM;
      cnt_d   = '0;
      valid_d = 1'b1;
      last_d  = 1'b0;
      re_d    = fft_real[FFT_W-1:0];
      im_d    = fft_imag[FFT_W-1:0];
    end
  end

  always_comb begin
    ovr_d = ovr_q;
    if (drop)             ovr_d = 1'b1;
    else if (clr_overrun) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ovr_q   <= ovr_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_idx   = cnt_q;
  assign out_real  = re_q;
  assign out_imag  = im_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_fft_8_result_streamer.sv
// Self-checking bench for fft_8_result_streamer: directed table, corner sequences, random vs model.
module tb_fft_8_result_streamer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fft_done;
  logic [127:0] fft_real, fft_imag;
  logic         cap_ready, out_valid, out_ready, out_last, overrun, clr_overrun;
  logic [15:0]  out_real, out_imag;
  logic [2:0]   out_idx;

  logic [15:0]  in_re [8];
  logic [15:0]  in_im [8];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one frame held, a beat pointer, and the sticky flag.
  bit           m_active;
  int           m_j;
  bit           m_ovr;
  logic [15:0]  m_re [8];
  logic [15:0]  m_im [8];

  fft_8_result_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fft_done    (fft_done),
    .fft_real    (fft_real),
    .fft_imag    (fft_imag),
    .cap_ready   (cap_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_real    (out_real),
    .out_imag    (out_imag),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    fft_real = '0;
    fft_imag = '0;
    for (int k = 0; k < 8; k++) begin
      fft_real[k*16 +: 16] = in_re[k];
      fft_imag[k*16 +: 16] = in_im[k];
    end
  end

  // Buffer position read on beat j.
  function automatic int perm(input int j);
`ifdef FFT_STREAM_BITREV_EN
    return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
`else
    return j;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_j      = 0;
    m_ovr    = 1'b0;
  endtask

  // Checks cap_ready before the edge, advances the model, then checks outputs after it.
  task automatic tick();
    bit cap, hs, lhs;
    #1;
    hs  = m_active && out_ready;
    lhs = hs && (m_j == 7);
    cap = !m_active || lhs;
    check("cap_ready", cap_ready, cap);
    if (fft_done && cap) begin
      for (int k = 0; k < 8; k++) begin
        m_re[k] = in_re[k];
        m_im[k] = in_im[k];
      end
      m_active = 1'b1;
      m_j      = 0;
    end else if (lhs) begin
      m_active = 1'b0;
      m_j      = 0;
    end else if (hs) begin
      m_j++;
    end
    if (fft_done && !cap) m_ovr = 1'b1;
    else if (clr_overrun) m_ovr = 1'b0;
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_active);
    if (m_active) begin
      check("out_idx",  out_idx,  m_j);
      check("out_last", out_last, m_j == 7);
      check("out_real", out_real, m_re[perm(m_j)]);
      check("out_imag", out_imag, m_im[perm(m_j)]);
    end
    check("overrun", overrun, m_ovr);
  endtask

  task automatic cycle(input bit d, input bit r, input bit c);
    fft_done    = d;
    out_ready   = r;
    clr_overrun = c;
    tick();
    fft_done    = 1'b0;
    clr_overrun = 1'b0;
  endtask

  task automatic load_a();
    for (int k = 0; k < 8; k++) begin
      in_re[k] = 16'(16'h0100 * k);
      in_im[k] = 16'(16'hFFFF - k);
    end
  endtask

  task automatic load_b();
    for (int k = 0; k < 8; k++) begin
      in_re[k] = 16'(16'hA000 + k);
      in_im[k] = 16'(k);
    end
  endtask

  typedef struct {
    bit done;
    bit ready;
    bit clr;
    bit e_valid;
    int e_idx;
    bit e_last;
    bit e_ovr;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1, 1, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 1, 0, 0};
    tbl[2]  = '{0, 1, 0, 1, 2, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 2, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 2, 0, 0};
    tbl[5]  = '{0, 1, 0, 1, 3, 0, 0};
    tbl[6]  = '{1, 0, 0, 1, 3, 0, 1};
    tbl[7]  = '{0, 1, 0, 1, 4, 0, 1};
    tbl[8]  = '{0, 1, 0, 1, 5, 0, 1};
    tbl[9]  = '{0, 1, 0, 1, 6, 0, 1};
    tbl[10] = '{0, 1, 0, 1, 7, 1, 1};
    tbl[11] = '{0, 0, 0, 1, 7, 1, 1};
    tbl[12] = '{0, 1, 0, 0, 0, 0, 1};
    tbl[13] = '{0, 0, 1, 0, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 1, 0, 0, 0};
    tbl[15] = '{1, 0, 1, 1, 0, 0, 1};

    rst_n       = 1'b0;
    fft_done    = 1'b0;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_re[k] = '0;
      in_im[k] = '0;
    end
    model_reset();

    // Reset state
    #3;
    check("rst out_valid", out_valid, 0);
    check("rst out_last",  out_last,  0);
    check("rst out_idx",   out_idx,   0);
    check("rst out_real",  out_real,  0);
    check("rst out_imag",  out_imag,  0);
    check("rst overrun",   overrun,   0);
    check("rst cap_ready", cap_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, full throughput
    load_a();
    cycle(1, 1, 0);
    for (int k = 0; k < 8; k++) begin
      check("sf valid", out_valid, 1);
      check("sf idx",   out_idx,   k);
      check("sf real",  out_real,  16'(16'h0100 * perm(k)));
      check("sf imag",  out_imag,  16'(16'hFFFF - perm(k)));
      check("sf last",  out_last,  k == 7);
      cycle(0, 1, 0);
    end
    check("sf valid after", out_valid, 0);

    // Backpressure, overrun drop at beat 3, clear, clear+drop
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].done, tbl[i].ready, tbl[i].clr);
      check($sformatf("tbl%0d valid", i), out_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d ovr", i),   overrun,   tbl[i].e_ovr);
      if (tbl[i].e_valid) begin
        check($sformatf("tbl%0d idx", i),  out_idx,  tbl[i].e_idx);
        check($sformatf("tbl%0d last", i), out_last, tbl[i].e_last);
        check($sformatf("tbl%0d real", i), out_real, 16'(16'h0100 * perm(tbl[i].e_idx)));
      end
    end
    repeat (9) cycle(0, 1, 0);
    cycle(0, 1, 1);
    check("ovr cleared", overrun, 0);

    // Back-to-back frames
    load_a();
    cycle(1, 1, 0);
    repeat (7) cycle(0, 1, 0);
    check("b2b last", out_last, 1);
    load_b();
    cycle(1, 1, 0);
    check("b2b valid", out_valid, 1);
    check("b2b idx",   out_idx,   0);
    check("b2b real",  out_real,  16'hA000);
    check("b2b ovr",   overrun,   0);
    repeat (8) cycle(0, 1, 0);
    check("b2b done", out_valid, 0);

    // Reset mid-frame at beat 4
    load_a();
    cycle(1, 1, 0);
    repeat (4) cycle(0, 1, 0);
    check("pre-rst idx", out_idx, 4);
    #2 rst_n = 1'b0;
    #1;
    check("mid-rst valid", out_valid, 0);
    check("mid-rst idx",   out_idx,   0);
    check("mid-rst last",  out_last,  0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(0, 1, 0);
    check("post-rst cap_ready", cap_ready, 1);
    load_b();
    cycle(1, 1, 0);
    check("post-rst idx",  out_idx,  0);
    check("post-rst real", out_real, 16'hA000);
    repeat (8) cycle(0, 1, 0);

`ifdef FFT_STREAM_BITREV_EN
    begin
      logic [15:0] exp_order [8];
      exp_order = '{16'h0000, 16'h0040, 16'h0020, 16'h0060,
                    16'h0010, 16'h0050, 16'h0030, 16'h0070};
      for (int k = 0; k < 8; k++) begin
        in_re[k] = 16'(16'h0010 * k);
        in_im[k] = '0;
      end
      cycle(1, 1, 0);
      for (int j = 0; j < 8; j++) begin
        check("bitrev idx",  out_idx,  j);
        check("bitrev real", out_real, exp_order[j]);
        cycle(0, 1, 0);
      end
    end
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 8; k++) begin
        in_re[k] = 16'($urandom);
        in_im[k] = 16'($urandom);
      end
      cycle(($urandom % 5) == 0, ($urandom % 3) != 0, ($urandom % 16) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
